// File: rtl/cache_data_array.sv
// Multi-way cache data store: registered parallel read of all ways, per-word masked write to one way,
// and a clear sequencer that zeroes every set after reset. Optional write-first forwarding: CACHE_DATA_ARRAY_BYPASS_EN.
module cache_data_array #(
    parameter int WAYS      = 2,
    parameter int SETS      = 256,
    parameter int LINE_BITS = 128,
    parameter int WORD_BITS = 32,
    localparam int INDEX_W  = (SETS > 1) ? $clog2(SETS) : 1,
    localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int WORDS    = LINE_BITS / WORD_BITS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      re,
    input  logic [INDEX_W-1:0]        rindex,
    output logic [WAYS*LINE_BITS-1:0] rdata,
    output logic                      rvalid,
    input  logic                      we,
    input  logic [WAY_W-1:0]          wway,
    input  logic [INDEX_W-1:0]        windex,
    input  logic [WORDS-1:0]          wword_en,
    input  logic [LINE_BITS-1:0]      wdata,
    output logic                      init_busy
);

    typedef enum logic {CLEAR, RUN} state_t;

    localparam logic [INDEX_W-1:0] LAST_SET = INDEX_W'(SETS - 1);

    state_t               state, state_n;
    logic [INDEX_W-1:0]   ptr, ptr_n;
    logic                 clr_en;
    logic                 rd_ok;
    logic                 wr_ok;
    logic [WAYS*LINE_BITS-1:0] rline_p0;
    logic [WAYS*LINE_BITS-1:0] rdata_p1;
    logic                 vld_p1;

    // ---- stage 0: control decode ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        case (state)
            CLEAR: begin
                ptr_n = ptr + 1'b1;
                if (ptr == LAST_SET) state_n = RUN;
            end
            RUN:     state_n = RUN;
            default: state_n = CLEAR;
        endcase
    end

    // Requests seen while clearing or in the reset cycle are dropped outright.
    assign clr_en    = (state == CLEAR) && !rst;
    assign rd_ok     = re && (state == RUN) && !rst;
    assign wr_ok     = we && (state == RUN) && !rst && (int'(wway) < WAYS);
    assign init_busy = (state == CLEAR);

    // ---- stage 0: per-way storage, write port and read mux ----
    for (genvar w = 0; w < WAYS; w++) begin : g_way
        logic [LINE_BITS-1:0] mem [SETS];
        logic                 wsel;
        logic [LINE_BITS-1:0] line_rd;

        assign wsel = wr_ok && ((WAYS == 1) || (int'(wway) == w));

        always_ff @(posedge clk) begin
            if (clr_en) begin
                mem[ptr] <= '0;
            end else if (wsel) begin
                for (int k = 0; k < WORDS; k++) begin
                    if (wword_en[k]) mem[windex][k*WORD_BITS +: WORD_BITS] <= wdata[k*WORD_BITS +: WORD_BITS];
                end
            end
        end

        always_comb begin
            line_rd = mem[rindex];
`ifdef CACHE_DATA_ARRAY_BYPASS_EN
            // Write-first: forward the enabled words of a same-set write into this read.
            if (wsel && (windex == rindex)) begin
                for (int k = 0; k < WORDS; k++) begin
                    if (wword_en[k]) line_rd[k*WORD_BITS +: WORD_BITS] = wdata[k*WORD_BITS +: WORD_BITS];
                end
            end
`endif
        end

        assign rline_p0[w*LINE_BITS +: LINE_BITS] = line_rd;
    end

    // ---- stage 1: registered read result ----
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_p1 <= '0;
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= rd_ok;
            if (rd_ok) rdata_p1 <= rline_p0;
        end
    end

    assign rdata  = rdata_p1;
    assign rvalid = vld_p1;

endmodule

// File: tb/tb_cache_data_array.sv
// Directed bench for cache_data_array (WAYS=2, SETS=256, 128-bit lines, 32-bit words).
module tb_cache_data_array;

    localparam int WAYS = 2;
    localparam int SETS = 256;
    localparam int LB   = 128;
    localparam int WB   = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              re = 1'b0;
    logic [7:0]        rindex = '0;
    logic [2*LB-1:0]   rdata;
    logic              rvalid;
    logic              we = 1'b0;
    logic [0:0]        wway = '0;
    logic [7:0]        windex = '0;
    logic [3:0]        wword_en = '0;
    logic [LB-1:0]     wdata = '0;
    logic              init_busy;

    int checks = 0;
    int errors = 0;
    int cnt;
    logic bad_vld;

    cache_data_array #(
        .WAYS(WAYS), .SETS(SETS), .LINE_BITS(LB), .WORD_BITS(WB)
    ) dut (
        .clk(clk), .rst(rst), .re(re), .rindex(rindex), .rdata(rdata), .rvalid(rvalid),
        .we(we), .wway(wway), .windex(windex), .wword_en(wword_en), .wdata(wdata),
        .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [2*LB-1:0] obs, input logic [2*LB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [0:0] way, input logic [7:0] idx, input logic [3:0] en, input logic [LB-1:0] d);
        we = 1'b1; wway = way; windex = idx; wword_en = en; wdata = d;
        step();
        we = 1'b0; wword_en = '0;
    endtask

    task automatic rd(input logic [7:0] idx);
        re = 1'b1; rindex = idx;
        step();
        re = 1'b0;
    endtask

    // Count cycles with init_busy high, bounded; rvalid must stay low throughout.
    task automatic count_busy(output int n, output logic vbad);
        n = 0;
        vbad = 1'b0;
        while (init_busy === 1'b1 && n < 1000) begin
            if (rvalid !== 1'b0) vbad = 1'b1;
            n++;
            step();
        end
    endtask

    initial begin
        // reset and full clear
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_init_busy", {255'd0, init_busy}, {255'd0, 1'b1});
        check("rst_rvalid",    {255'd0, rvalid},    256'd0);
        check("rst_rdata",     rdata,               256'd0);
        count_busy(cnt, bad_vld);
        check("clear_cycles", 256'(cnt), 256'd256);

        rd(8'd0);
        check("rd0_rvalid", {255'd0, rvalid}, {255'd0, 1'b1});
        check("rd0_data",   rdata,            256'd0);
        rd(8'd255);
        check("rd255_data", rdata, 256'd0);

        // full-line write to way1, then masked word-2 merge
        wr(1'b1, 8'h12, 4'b1111, {4{32'hAAAAAAAA}});
        rd(8'h12);
        check("full_wr_rvalid", {255'd0, rvalid}, {255'd0, 1'b1});
        check("full_wr_data",   rdata, {{4{32'hAAAAAAAA}}, 128'd0});
        wr(1'b1, 8'h12, 4'b0100, {32'h11111111, 32'hDEADBEEF, 32'h22222222, 32'h33333333});
        rd(8'h12);
        check("merge_data", rdata, {32'hAAAAAAAA, 32'hDEADBEEF, 32'hAAAAAAAA, 32'hAAAAAAAA, 128'd0});

        // same-cycle read and write to set 0x30 way0
        re = 1'b1; rindex = 8'h30;
        we = 1'b1; wway = 1'b0; windex = 8'h30; wword_en = 4'b1111; wdata = 128'h1;
        step();
        we = 1'b0; wword_en = '0;
`ifdef CACHE_DATA_ARRAY_BYPASS_EN
        check("same_cycle_rw", rdata, {128'd0, 128'h1});
`else
        check("same_cycle_rw", rdata, 256'd0);
`endif
        step();
        re = 1'b0;
        check("after_rw", rdata, {128'd0, 128'h1});

        // preload sets 1..4 in both ways, check an all-disabled write does nothing
        for (int i = 1; i <= 4; i++) begin
            wr(1'b0, 8'(i), 4'b1111, 128'(i));
            wr(1'b1, 8'(i), 4'b1111, 128'(32'h10 + i));
        end
        wr(1'b0, 8'd1, 4'b0000, {4{32'hFFFFFFFF}});
        rd(8'd1);
        check("noop_wr", rdata, {128'h11, 128'h1});

        // back-to-back reads
        re = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            rindex = 8'(i);
            step();
            check("b2b_data",   rdata, {128'(32'h10 + i), 128'(i)});
            check("b2b_rvalid", {255'd0, rvalid}, {255'd0, 1'b1});
        end
        re = 1'b0;
        step();
        check("drop_rvalid", {255'd0, rvalid}, 256'd0);
        check("drop_hold",   rdata, {128'h14, 128'h4});

        // reset partway through a clear; requests during clear are dropped
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (100) step();
        check("mid_clear_busy", {255'd0, init_busy}, {255'd0, 1'b1});
        rst = 1'b1;
        step();
        rst = 1'b0;
        re = 1'b1; rindex = 8'd0;
        we = 1'b1; wway = 1'b0; windex = 8'd0; wword_en = 4'b1111; wdata = {4{32'hFFFFFFFF}};
        count_busy(cnt, bad_vld);
        re = 1'b0; we = 1'b0; wword_en = '0;
        check("restart_cycles",    256'(cnt), 256'd256);
        check("clear_rvalid_low",  {255'd0, bad_vld}, 256'd0);
        rd(8'd0);
        check("clear_no_write", rdata, 256'd0);
        rd(8'd3);
        check("cleared_set3", rdata, 256'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
